// File: rtl/fb_write_sequencer.sv
// Decodes the SPI word stream into frame-RAM writes and display commands,
// double-buffering the RAM and applying bank/position changes only on REFRESH.
module fb_write_sequencer #(
  parameter int unsigned PIC_X   = 120,
  parameter int unsigned PIC_Y   = 120,
  parameter int unsigned PIC     = PIC_X * PIC_Y,
  parameter int unsigned X_RESET = 280,
  parameter int unsigned Y_RESET = 200
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WORD_VALID,
  input  logic [15:0] WORD_DATA,
  input  logic        MSG_END,
  input  logic        REFRESH,
  output logic        WR_EN,
  output logic [14:0] WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        RD_BANK,
  output logic [10:0] POS_X,
  output logic [9:0]  POS_Y,
  output logic        FRAME_DONE,
  output logic        ERR_SHORT,
  output logic        ERR_OVERRUN
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PIXELS    = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;
  localparam logic [1:0] ST_DISCARD   = 2'd3;

  localparam logic [3:0] OP_FRAME = 4'h1;
  localparam logic [3:0] OP_SET_X = 4'h2;
  localparam logic [3:0] OP_SET_Y = 4'h3;

  localparam logic [13:0] PIC_IDX  = 14'(PIC);
  localparam logic [14:0] PIC_ADDR = 15'(PIC);
  localparam logic [10:0] X_RST    = 11'(X_RESET);
  localparam logic [9:0]  Y_RST    = 10'(Y_RESET);

  logic [1:0]  state_q, state_d;
  logic [13:0] index_q, index_d;
  logic        rd_bank_q, rd_bank_d;
  logic [10:0] pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic [10:0] shadow_x_q, shadow_x_d;
  logic [9:0]  shadow_y_q, shadow_y_d;
  // Set from the second WAIT_SWAP cycle on, so a REFRESH landing on the final write is not used.
  logic        armed_q, armed_d;
  logic        wr_en_q, wr_en_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;
  logic        err_short_q, err_short_d;
  logic        err_overrun_q, err_overrun_d;
  logic [14:0] wr_base_s;

  assign wr_base_s = rd_bank_q ? 15'd0 : PIC_ADDR;

  // Next-state decode for the sequencer FSM and all registered outputs.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    rd_bank_d     = rd_bank_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    shadow_x_d    = shadow_x_q;
    shadow_y_d    = shadow_y_q;
    armed_d       = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    err_short_d   = 1'b0;
    err_overrun_d = 1'b0;

    if (REFRESH && (state_q != ST_WAIT_SWAP)) begin
      pos_x_d = shadow_x_q;
      pos_y_d = shadow_y_q;
    end else begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (WORD_VALID) begin
          case (WORD_DATA[15:12])
            OP_FRAME: begin
              index_d = 14'd0;
              if (MSG_END) begin
                err_short_d = 1'b1;
                state_d     = ST_IDLE;
              end else begin
                state_d = ST_PIXELS;
              end
            end
            OP_SET_X: begin
              shadow_x_d = WORD_DATA[10:0];
              state_d    = MSG_END ? ST_IDLE : ST_DISCARD;
            end
            OP_SET_Y: begin
              shadow_y_d = WORD_DATA[9:0];
              state_d    = MSG_END ? ST_IDLE : ST_DISCARD;
            end
            default: begin
              state_d = MSG_END ? ST_IDLE : ST_DISCARD;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PIXELS: begin
        if (WORD_VALID) begin
          wr_en_d   = 1'b1;
          wr_data_d = WORD_DATA;
          wr_addr_d = wr_base_s + {1'b0, index_q};
          index_d   = index_q + 14'd1;
        end else begin
          index_d = index_q;
        end
        // The word is counted before MSG_END is judged, so a last pixel with MSG_END is not short.
        if (index_d == PIC_IDX) begin
          state_d = ST_WAIT_SWAP;
        end else if (MSG_END) begin
          err_short_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_PIXELS;
        end
      end

      ST_WAIT_SWAP: begin
        armed_d       = 1'b1;
        err_overrun_d = WORD_VALID;
        if (REFRESH && armed_q) begin
          rd_bank_d    = ~rd_bank_q;
          pos_x_d      = shadow_x_q;
          pos_y_d      = shadow_y_q;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_WAIT_SWAP;
        end
      end

      ST_DISCARD: begin
        if (MSG_END) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      index_q       <= 14'd0;
      rd_bank_q     <= 1'b0;
      pos_x_q       <= X_RST;
      pos_y_q       <= Y_RST;
      shadow_x_q    <= X_RST;
      shadow_y_q    <= Y_RST;
      armed_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 15'd0;
      wr_data_q     <= 16'd0;
      frame_done_q  <= 1'b0;
      err_short_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      rd_bank_q     <= rd_bank_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      shadow_x_q    <= shadow_x_d;
      shadow_y_q    <= shadow_y_d;
      armed_q       <= armed_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      err_short_q   <= err_short_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign WR_EN       = wr_en_q;
  assign WR_ADDR     = wr_addr_q;
  assign WR_DATA     = wr_data_q;
  assign RD_BANK     = rd_bank_q;
  assign POS_X       = pos_x_q;
  assign POS_Y       = pos_y_q;
  assign FRAME_DONE  = frame_done_q;
  assign ERR_SHORT   = err_short_q;
  assign ERR_OVERRUN = err_overrun_q;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Bench for fb_write_sequencer: random pixel data and gaps, checked against a
// frame-level model of bank, shadow and display position.
module tb_fb_write_sequencer;

  localparam int PIC = 14400;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WORD_VALID;
  logic [15:0] WORD_DATA;
  logic        MSG_END;
  logic        REFRESH;
  logic        WR_EN;
  logic [14:0] WR_ADDR;
  logic [15:0] WR_DATA;
  logic        RD_BANK;
  logic [10:0] POS_X;
  logic [9:0]  POS_Y;
  logic        FRAME_DONE;
  logic        ERR_SHORT;
  logic        ERR_OVERRUN;

  int errors = 0;
  int checks = 0;

  int model_bank;
  int model_x;
  int model_y;
  int sh_x;
  int sh_y;

  fb_write_sequencer dut (
    .CLK(CLK), .RESET(RESET), .WORD_VALID(WORD_VALID), .WORD_DATA(WORD_DATA),
    .MSG_END(MSG_END), .REFRESH(REFRESH), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .RD_BANK(RD_BANK), .POS_X(POS_X), .POS_Y(POS_Y),
    .FRAME_DONE(FRAME_DONE), .ERR_SHORT(ERR_SHORT), .ERR_OVERRUN(ERR_OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Present one set of strobes for a single clock; on return the registered response is visible.
  task automatic drive(input logic wv, input logic [15:0] w, input logic me, input logic rf);
    WORD_VALID = wv; WORD_DATA = w; MSG_END = me; REFRESH = rf;
    cycle();
    WORD_VALID = 1'b0; MSG_END = 1'b0; REFRESH = 1'b0;
  endtask

  task automatic model_reset();
    model_bank = 0; model_x = 280; model_y = 200; sh_x = 280; sh_y = 200;
  endtask

  // Streams n random pixels with random gaps; bad counts every cycle that deviates from the model.
  task automatic stream_pixels(input int n, input bit end_on_last, output int bad);
    logic [15:0] d;
    int exp_addr;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(7) == 0) begin
        cycle();
        if (WR_EN !== 1'b0) bad++;
      end
      d = 16'($urandom);
      exp_addr = (model_bank == 1 ? 0 : PIC) + i;
      drive(1'b1, d, end_on_last && (i == n - 1), 1'b0);
      if (WR_EN !== 1'b1 || WR_ADDR !== 15'(exp_addr) || WR_DATA !== d) bad++;
      if (ERR_SHORT !== 1'b0 || ERR_OVERRUN !== 1'b0 || FRAME_DONE !== 1'b0) bad++;
    end
  endtask

  task automatic expect_swap(input string name);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    model_bank = 1 - model_bank;
    model_x = sh_x; model_y = sh_y;
    checks++;
    if (FRAME_DONE !== 1'b1) begin errors++; $display("FAIL %s_frame_done: got %0b want 1", name, FRAME_DONE); end
    checks++;
    if (RD_BANK !== model_bank[0]) begin errors++; $display("FAIL %s_rd_bank: got %0b want %0d", name, RD_BANK, model_bank); end
    checks++;
    if (POS_X !== 11'(model_x) || POS_Y !== 10'(model_y)) begin
      errors++; $display("FAIL %s_pos: got %0d,%0d want %0d,%0d", name, POS_X, POS_Y, model_x, model_y);
    end
    cycle();
    checks++;
    if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL %s_frame_done_width: got %0b want 0", name, FRAME_DONE); end
  endtask

  task automatic test_reset();
    int bad = 0;
    RESET = 1'b1; WORD_VALID = 1'b0; WORD_DATA = 16'd0; MSG_END = 1'b0; REFRESH = 1'b0;
    repeat (3) cycle();
    #2 RESET = 1'b0;
    model_reset();
    cycle();
    checks++;
    if (RD_BANK !== 1'b0) begin errors++; $display("FAIL reset_rd_bank: got %0b want 0", RD_BANK); end
    checks++;
    if (POS_X !== 11'd280 || POS_Y !== 10'd200) begin errors++; $display("FAIL reset_pos: got %0d,%0d want 280,200", POS_X, POS_Y); end
    checks++;
    if (WR_EN !== 1'b0 || WR_ADDR !== 15'd0 || WR_DATA !== 16'd0) begin
      errors++; $display("FAIL reset_write_port: got en=%0b addr=%0d data=%0h want 0,0,0", WR_EN, WR_ADDR, WR_DATA);
    end
    checks++;
    if (FRAME_DONE !== 1'b0 || ERR_SHORT !== 1'b0 || ERR_OVERRUN !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got %0b%0b%0b want 000", FRAME_DONE, ERR_SHORT, ERR_OVERRUN);
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 16'd0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      if (WR_EN !== 1'b0 || FRAME_DONE !== 1'b0 || ERR_SHORT !== 1'b0 || ERR_OVERRUN !== 1'b0) bad++;
      if (RD_BANK !== 1'b0 || POS_X !== 11'd280 || POS_Y !== 10'd200) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_full_frame();
    int bad;
    drive(1'b1, 16'h1000, 1'b0, 1'b0);
    checks++;
    if (WR_EN !== 1'b0) begin errors++; $display("FAIL header_no_write: got %0b want 0", WR_EN); end
    stream_pixels(PIC, 1'b0, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame1_writes: got %0d bad want 0", bad); end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    checks++;
    if (RD_BANK !== 1'b0 || ERR_SHORT !== 1'b0 || WR_EN !== 1'b0) begin
      errors++; $display("FAIL frame1_msg_end: got bank=%0b short=%0b en=%0b want 0,0,0", RD_BANK, ERR_SHORT, WR_EN);
    end
    expect_swap("frame1");
  endtask

  task automatic test_back_to_back();
    int bad;
    drive(1'b1, 16'h1000, 1'b0, 1'b0);
    stream_pixels(PIC, 1'b1, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame2_writes: got %0d bad want 0", bad); end
    cycle();
    checks++;
    if (ERR_SHORT !== 1'b0 || RD_BANK !== 1'b1) begin
      errors++; $display("FAIL frame2_last_with_end: got short=%0b bank=%0b want 0,1", ERR_SHORT, RD_BANK);
    end
    expect_swap("frame2");
  endtask

  task automatic test_position();
    int bad = 0;
    int x;
    int y;
    logic [3:0] op;
    drive(1'b1, 16'h2064, 1'b1, 1'b0);
    drive(1'b1, 16'h3032, 1'b1, 1'b0);
    sh_x = 100; sh_y = 50;
    checks++;
    if (POS_X !== 11'(model_x) || POS_Y !== 10'(model_y)) begin
      errors++; $display("FAIL pos_before_refresh: got %0d,%0d want %0d,%0d", POS_X, POS_Y, model_x, model_y);
    end
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    model_x = sh_x; model_y = sh_y;
    checks++;
    if (POS_X !== 11'd100 || POS_Y !== 10'd50 || RD_BANK !== model_bank[0] || FRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL pos_after_refresh: got %0d,%0d bank=%0b done=%0b want 100,50,%0d,0", POS_X, POS_Y, RD_BANK, FRAME_DONE, model_bank);
    end
    x = $urandom_range(2047);
    y = $urandom_range(1023);
    drive(1'b1, {4'h2, 1'b0, 11'(x)}, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      if (WR_EN !== 1'b0 || ERR_OVERRUN !== 1'b0) bad++;
    end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    op = 4'($urandom_range(4, 15));
    drive(1'b1, {op, 12'($urandom)}, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      if (WR_EN !== 1'b0 || ERR_OVERRUN !== 1'b0) bad++;
    end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    drive(1'b1, {4'h3, 2'b00, 10'(y)}, 1'b1, 1'b0);
    sh_x = x; sh_y = y;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL discard_quiet: got %0d bad want 0", bad); end
    checks++;
    if (POS_X !== 11'(model_x) || POS_Y !== 10'(model_y)) begin
      errors++; $display("FAIL rand_pos_before_refresh: got %0d,%0d want %0d,%0d", POS_X, POS_Y, model_x, model_y);
    end
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    model_x = sh_x; model_y = sh_y;
    checks++;
    if (POS_X !== 11'(model_x) || POS_Y !== 10'(model_y) || RD_BANK !== model_bank[0]) begin
      errors++; $display("FAIL rand_pos_after_refresh: got %0d,%0d bank=%0b want %0d,%0d,%0d", POS_X, POS_Y, RD_BANK, model_x, model_y, model_bank);
    end
  endtask

  task automatic test_overrun();
    int bad;
    int ovr = 0;
    int wr = 0;
    drive(1'b1, 16'h1000, 1'b0, 1'b0);
    stream_pixels(PIC, 1'b0, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL frame3_writes: got %0d bad want 0", bad); end
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    checks++;
    if (RD_BANK !== model_bank[0] || FRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL early_refresh_ignored: got bank=%0b done=%0b want %0d,0", RD_BANK, FRAME_DONE, model_bank);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      if (ERR_OVERRUN === 1'b1) ovr++;
      if (WR_EN !== 1'b0) wr++;
    end
    cycle();
    if (ERR_OVERRUN === 1'b1) ovr++;
    checks++;
    if (ovr !== 3) begin errors++; $display("FAIL overrun_pulses: got %0d want 3", ovr); end
    checks++;
    if (wr !== 0) begin errors++; $display("FAIL overrun_no_write: got %0d want 0", wr); end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    checks++;
    if (RD_BANK !== model_bank[0] || ERR_SHORT !== 1'b0) begin
      errors++; $display("FAIL wait_msg_end_ignored: got bank=%0b short=%0b want %0d,0", RD_BANK, ERR_SHORT, model_bank);
    end
    expect_swap("frame3");
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    drive(1'b1, 16'h1000, 1'b0, 1'b0);
    stream_pixels(7000, 1'b0, bad);
    checks++;
    if (bad !== 0 || WR_EN !== 1'b1) begin errors++; $display("FAIL partial_writes: got %0d bad en=%0b want 0,1", bad, WR_EN); end
    #2 RESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if (WR_EN !== 1'b0 || WR_ADDR !== 15'd0) begin
      errors++; $display("FAIL async_reset_write: got en=%0b addr=%0d want 0,0", WR_EN, WR_ADDR);
    end
    checks++;
    if (RD_BANK !== 1'b0 || POS_X !== 11'd280 || POS_Y !== 10'd200) begin
      errors++; $display("FAIL async_reset_display: got bank=%0b pos=%0d,%0d want 0,280,200", RD_BANK, POS_X, POS_Y);
    end
    cycle();
    RESET = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    checks++;
    if (RD_BANK !== 1'b0 || POS_X !== 11'd280 || POS_Y !== 10'd200 || FRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL post_reset_refresh: got bank=%0b pos=%0d,%0d done=%0b want 0,280,200,0", RD_BANK, POS_X, POS_Y, FRAME_DONE);
    end
  endtask

  task automatic test_short_frame();
    int bad;
    drive(1'b1, 16'h1000, 1'b0, 1'b0);
    stream_pixels(500, 1'b0, bad);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL short_writes: got %0d bad want 0", bad); end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    checks++;
    if (ERR_SHORT !== 1'b1) begin errors++; $display("FAIL err_short: got %0b want 1", ERR_SHORT); end
    cycle();
    checks++;
    if (ERR_SHORT !== 1'b0) begin errors++; $display("FAIL err_short_width: got %0b want 0", ERR_SHORT); end
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    checks++;
    if (RD_BANK !== 1'b0 || FRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL short_no_swap: got bank=%0b done=%0b want 0,0", RD_BANK, FRAME_DONE);
    end
    drive(1'b1, 16'h2064, 1'b1, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    checks++;
    if (POS_X !== 11'd100) begin errors++; $display("FAIL short_back_to_idle: got %0d want 100", POS_X); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_position();
    test_overrun();
    test_reset_mid_frame();
    test_short_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
